upower_fetch_decode: RTL

Instruction fetch and decode front end for the uPower R/I-type datapath. Holds the program counter and a word-addressed instruction memory. Fetches one 32-bit instruction at a time and decodes add, addi, and, andi., or, ori into the datapath control signals ALU_OP, RegWrite, RegDst, ALUSrc and XO. Presents the instruction and controls to the downstream R/I-type datapath through a valid/ready handshake.

---
 rtl/upower_fetch_decode.sv | 95 +++++++++
 1 files changed

// File: rtl/upower_fetch_decode.sv
// upower_fetch_decode: PC, word-addressed imem and R/I-type decoder issuing to the datapath via valid/ready.
module upower_fetch_decode #(
  parameter int IMEM_DEPTH = 64,
  parameter int PC_W = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  input  logic [31:0]                   imem_wdata,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [31:0]                   instruction,
  output logic [3:0]                    ALU_OP,
  output logic                          RegWrite,
  output logic                          RegDst,
  output logic                          ALUSrc,
  output logic                          XO,
  output logic [PC_W-1:0]               pc,
  output logic                          halted,
  output logic                          error
);
  localparam int AW = $clog2(IMEM_DEPTH);
  localparam logic [PC_W-1:0] END_PC = PC_W'(IMEM_DEPTH * 4);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, ISSUE, HALT} state_t;
  state_t state, state_nxt;
  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] ir;
  logic rw;
  logic [5:0] op;
  logic [9:0] xo_f;
  logic is_add, is_and, is_or, is_addi, is_andi, is_ori, legal;
  logic [3:0] dec_alu;
  logic [PC_W-1:0] pc_inc;
  assign instruction = ir;
  assign op = ir[31:26];
  assign xo_f = ir[10:1];
  assign is_add = op == 6'd31 && xo_f == 10'd266;
  assign is_and = op == 6'd31 && xo_f == 10'd28;
  assign is_or = op == 6'd31 && xo_f == 10'd444;
  assign is_addi = op == 6'd14;
  assign is_andi = op == 6'd28;
  assign is_ori = op == 6'd24;
  assign legal = is_add | is_and | is_or | is_addi | is_andi | is_ori;
  assign dec_alu = (is_add | is_addi) ? 4'b0010 : (is_or | is_ori) ? 4'b0001 : 4'b0000;
  assign pc_inc = pc + PC_W'(4);
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? FETCH : IDLE;
      FETCH:   state_nxt = DECODE;
      DECODE:  state_nxt = legal ? ISSUE : HALT;
      ISSUE:   state_nxt = !out_ready ? ISSUE : (pc_inc == END_PC) ? HALT : FETCH;
      default: state_nxt = HALT;
    endcase
  end
  // A reset arriving during ISSUE must suppress the register-file write in that same cycle
  always_comb begin
    out_valid = state == ISSUE;
    halted = state == HALT;
    RegWrite = rw & out_valid & out_ready & rst;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= '0;
      ir <= '0;
      ALU_OP <= '0;
      ALUSrc <= 1'b0;
      RegDst <= 1'b0;
      XO <= 1'b0;
      rw <= 1'b0;
      error <= 1'b0;
    end else begin
      if (state == FETCH) ir <= imem[pc[AW+1:2]];
      if (state == DECODE) begin
        ALU_OP <= dec_alu;
        ALUSrc <= is_addi | is_andi | is_ori;
        RegDst <= is_add | is_and | is_or;
        XO <= is_add | is_addi;
        rw <= legal;
        error <= !legal && ir != '0;
      end
      if (state == ISSUE && out_ready) pc <= pc_inc;
    end
  end
  // Memory has no reset so a program survives rst
  always_ff @(posedge clk) begin
    if (state == IDLE && imem_we) imem[imem_addr] <= imem_wdata;
  end
endmodule
